// File: rtl/vu_vxu_bptr_ring_if.sv
// Handshake and status bundle between VXU issue/retire logic and the bank-ring pointer owner.
interface vu_vxu_bptr_ring_if #(
  parameter int unsigned SZ_BPTR = 3,
  parameter int unsigned SZ_BCNT = 4,
  parameter int unsigned SZ_LOOK = 4
);
  logic               cfg_val;
  logic               cfg_rdy;
  logic [SZ_BCNT-1:0] cfg_bcnt;
  logic               issue_val;
  logic               issue_rdy;
  logic               retire_val;
  logic [SZ_LOOK-1:0] look_incr;
  logic [SZ_BPTR-1:0] head;
  logic [SZ_BPTR-1:0] tail;
  logic [SZ_BPTR-1:0] look_ptr;
  logic [SZ_BCNT-1:0] count;
  logic               full;
  logic               empty;
  logic [SZ_BCNT-1:0] bcnt;
  logic               err;

  modport master (
    output cfg_val, cfg_bcnt, issue_val, retire_val, look_incr,
    input  cfg_rdy, issue_rdy, head, tail, look_ptr, count, full, empty, bcnt, err
  );

  modport slave (
    input  cfg_val, cfg_bcnt, issue_val, retire_val, look_incr,
    output cfg_rdy, issue_rdy, head, tail, look_ptr, count, full, empty, bcnt, err
  );
endinterface

// File: rtl/vu_vxu_bptr_ring.sv
// VXU bank-ring head/tail pointer owner with programmable bank count and modulo lookahead.
// Define VU_BPTR_ERR_EN to build the sticky protocol-error flag; otherwise err is tied low.
module vu_vxu_bptr_ring #(
  parameter int unsigned SZ_BPTR = 3,
  parameter int unsigned SZ_BCNT = 4,
  parameter int unsigned SZ_LOOK = 4
) (
  input logic             clk,
  input logic             reset,
  vu_vxu_bptr_ring_if.slave ring
);

  localparam int unsigned SzSum     = SZ_LOOK + 1;
  // Max sum 17 against min bcnt 3 needs at most 5 conditional subtractions.
  localparam int unsigned LookSteps = 5;
  localparam logic [SZ_BCNT-1:0] BcntMin   = SZ_BCNT'(3);
  localparam logic [SZ_BCNT-1:0] BcntMax   = SZ_BCNT'(8);

  logic [SZ_BPTR-1:0] head_q, head_d;
  logic [SZ_BPTR-1:0] tail_q, tail_d;
  logic [SZ_BCNT-1:0] count_q, count_d;
  logic [SZ_BCNT-1:0] bcnt_q, bcnt_d;

  logic full, empty;
  logic cfg_fire, cfg_legal, issue_fire, retire_fire;
  logic [SzSum-1:0] look_mod;

  function automatic logic [SZ_BPTR-1:0] next_ptr(input logic [SZ_BPTR-1:0] p,
                                                  input logic [SZ_BCNT-1:0] n);
    if (SZ_BCNT'(p) + SZ_BCNT'(1) == n) return '0;
    return p + SZ_BPTR'(1);
  endfunction

  assign empty       = (count_q == '0);
  assign full        = (count_q == bcnt_q);
  assign cfg_fire    = ring.cfg_val & empty;
  assign cfg_legal   = (ring.cfg_bcnt >= BcntMin) && (ring.cfg_bcnt <= BcntMax);
  assign issue_fire  = ring.issue_val & ring.issue_rdy;
  assign retire_fire = ring.retire_val & ~empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    bcnt_d  = bcnt_q;
    if (cfg_fire) begin
      // Ring is empty here, so count stays 0 and retire cannot fire.
      if (cfg_legal) begin
        bcnt_d = ring.cfg_bcnt;
        head_d = '0;
        tail_d = '0;
      end
    end else begin
      if (issue_fire)  head_d = next_ptr(head_q, bcnt_q);
      if (retire_fire) tail_d = next_ptr(tail_q, bcnt_q);
      case ({issue_fire, retire_fire})
        2'b10:   count_d = count_q + SZ_BCNT'(1);
        2'b01:   count_d = count_q - SZ_BCNT'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      bcnt_q  <= BcntMax;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    look_mod = SzSum'(head_q) + SzSum'(ring.look_incr);
    for (int i = 0; i < LookSteps; i++) begin
      if (look_mod >= SzSum'(bcnt_q)) look_mod = look_mod - SzSum'(bcnt_q);
    end
  end

`ifdef VU_BPTR_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((ring.retire_val & empty) | (cfg_fire & ~cfg_legal) |
        (ring.issue_val & full) | (ring.cfg_val & ~empty)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign ring.err = err_q;
`else
  assign ring.err = 1'b0;
`endif

  assign ring.cfg_rdy   = empty;
  assign ring.issue_rdy = ~full & ~cfg_fire;
  assign ring.head      = head_q;
  assign ring.tail      = tail_q;
  assign ring.count     = count_q;
  assign ring.bcnt      = bcnt_q;
  assign ring.full      = full;
  assign ring.empty     = empty;
  assign ring.look_ptr  = SZ_BPTR'(look_mod);

endmodule

// File: tb/tb_vu_vxu_bptr_ring.sv
// Scoreboard bench for vu_vxu_bptr_ring: a claims-queue reference model predicts each cycle.
module tb_vu_vxu_bptr_ring;

`ifdef VU_BPTR_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  vu_vxu_bptr_ring_if #(.SZ_BPTR(3), .SZ_BCNT(4), .SZ_LOOK(4)) ring ();

  vu_vxu_bptr_ring #(.SZ_BPTR(3), .SZ_BCNT(4), .SZ_LOOK(4)) dut (
    .clk  (clk),
    .reset(reset),
    .ring (ring)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit chk;
    int head, tail, count, bcnt;
    bit full, empty, err, issue_rdy, cfg_rdy;
    bit look_chk;
    int look;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: the claimed banks themselves, oldest first.
  int claims[$];
  int m_head = 0, m_tail = 0, m_bcnt = 8;
  bit m_err = 1'b0;
  bit m_init = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit cv, input int cb, input bit iv, input bit rv,
                      input int li);
    exp_t e;
    int   cnt;
    int   popped;
    bit   emp, ful;
    reset           = r;
    ring.cfg_val    = cv;
    ring.cfg_bcnt   = cb[3:0];
    ring.issue_val  = iv;
    ring.retire_val = rv;
    ring.look_incr  = li[3:0];
    cnt         = claims.size();
    emp         = (cnt == 0);
    ful         = (cnt == m_bcnt);
    e.chk       = m_init;
    e.head      = m_head;
    e.tail      = m_tail;
    e.count     = cnt;
    e.bcnt      = m_bcnt;
    e.full      = ful;
    e.empty     = emp;
    e.err       = m_err;
    e.cfg_rdy   = emp;
    e.issue_rdy = !ful && !(cv && emp);
    e.look_chk  = m_init && (li <= 10);
    e.look      = (m_head + li) % m_bcnt;
    exp_q.push_back(e);
    @(posedge clk);
    if (r) begin
      claims.delete();
      m_head = 0;
      m_tail = 0;
      m_bcnt = 8;
      m_err  = 1'b0;
      m_init = 1'b1;
    end else begin
      if (ErrEn && ((rv && emp) || (cv && emp && !(cb >= 3 && cb <= 8)) || (iv && ful) ||
                    (cv && !emp))) m_err = 1'b1;
      if (cv && emp) begin
        if (cb >= 3 && cb <= 8) begin
          m_bcnt = cb;
          m_head = 0;
          m_tail = 0;
        end
      end else begin
        if (rv && !emp) begin
          popped = claims.pop_front();
          m_tail = (popped + 1) % m_bcnt;
        end
        if (iv && !ful) begin
          claims.push_back(m_head);
          m_head = (m_head + 1) % m_bcnt;
        end
      end
    end
    #1;
  endtask

  // Monitor: DUT status is always presented, so one expectation is retired per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          cmp("head", 32'(ring.head), 32'(e.head));
          cmp("tail", 32'(ring.tail), 32'(e.tail));
          cmp("count", 32'(ring.count), 32'(e.count));
          cmp("bcnt", 32'(ring.bcnt), 32'(e.bcnt));
          cmp("full", 32'(ring.full), 32'(e.full));
          cmp("empty", 32'(ring.empty), 32'(e.empty));
          cmp("err", 32'(ring.err), 32'(e.err));
          cmp("issue_rdy", 32'(ring.issue_rdy), 32'(e.issue_rdy));
          cmp("cfg_rdy", 32'(ring.cfg_rdy), 32'(e.cfg_rdy));
          if (e.look_chk) cmp("look_ptr", 32'(ring.look_ptr), 32'(e.look));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    ring.cfg_val = 1'b0;
    ring.cfg_bcnt = '0;
    ring.issue_val = 1'b0;
    ring.retire_val = 1'b0;
    ring.look_incr = '0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Fill the default 8-bank ring, then one extra issue that must be dropped.
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0, i);
    step(0, 0, 0, 0, 0, 10);
    // Reconfigure to 3 banks and walk paired issue/retire around the wrap.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 3, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 2);
    step(0, 0, 0, 0, 1, 0);
    // 5 banks: fill, then simultaneous issue+retire while full.
    step(0, 1, 5, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 3);
    step(0, 0, 0, 1, 1, 4);
    step(0, 0, 0, 0, 0, 9);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // Illegal bank counts and cfg while occupied.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0);
    step(0, 1, 9, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 4, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Reset with count=4, head=6.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 5);
    // Lookahead sweep over every legal bcnt, head and increment.
    for (int b = 3; b <= 8; b++) begin
      step(0, 1, b, 0, 0, 0);
      for (int h = 0; h < b; h++) begin
        for (int li = 0; li <= 10; li++) step(0, 0, 0, 0, 0, li);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
      end
    end
    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      bit r, cv, iv, rv;
      int cb, li;
      r  = ($urandom_range(0, 199) == 0);
      cv = ($urandom_range(0, 9) == 0);
      cb = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) cb = $urandom_range(3, 8);
      iv = ($urandom_range(0, 1) == 1);
      rv = ($urandom_range(0, 9) < 4);
      li = ($urandom_range(0, 15) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
      step(r, cv, cb, iv, rv, li);
    end
    @(negedge clk);
    #1;
    cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
